// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the capture-path write arbiter and the read-side
//   demultiplexer: FSM state encoding, the default header tag and the
//   header-word builder.
//   No ports (package).
package fifo_arb_pkg;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } arb_state_e;

  // Upper bits of every header word; the ID fills the low bits.
  localparam logic [4:0] HDR_TAG_DEFAULT = 5'b10100;

  // Build a header word {tag, id}. Operands are carried at 32 bits so one
  // function serves every DW/IDW combination; callers truncate to DW.
  function automatic logic [31:0] build_hdr(input logic [31:0] tag,
                                            input logic [31:0] id,
                                            input int unsigned idw);
    logic [31:0] mask;
    mask = (32'd1 << idw) - 32'd1;
    return (tag << idw) | (id & mask);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority picker. Returns the first asserted
//   request at or after i_ptr, wrapping from NREQ-1 back to 0.
//   Ports:
//     i_req [NREQ]  request vector
//     i_ptr [IDW]   highest-priority index this round (must be < NREQ)
//     o_any         at least one request asserted
//     o_idx [IDW]   index of the winner (0 when o_any is low)
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_any,
  output logic [IDW-1:0]  o_idx
);

  // Scan priority offsets k = 0..NREQ-1 from the pointer; the first hit wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!o_any && i_req[j] && (j == ((int'(i_ptr) + k) % NREQ))) begin
          o_any = 1'b1;
          o_idx = IDW'(j);
        end else begin
          o_any = o_any;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Packet-atomic round-robin arbiter sharing the single write port of the
//   capture-path ASYNC_FIFO among NREQ byte-stream requesters. Each packet is
//   preceded by a one-word header {HDR_TAG, id}; packets longer than MAXLEN
//   beats are cut and the remainder is sent as a fresh packet.
//   Ports (all in the wclk domain):
//     wclk            clock (FIFO write clock)
//     rst             synchronous active-low reset (not forwarded to the FIFO)
//     i_req_valid     per-requester beat valid
//     i_req_data      requester i at [i*DW +: DW]
//     i_req_last      per-requester final beat of packet
//     o_req_ready     per-requester beat accepted when valid && ready
//     i_fifo_full     FIFO full
//     o_fifo_enqueue  FIFO enqueue (never high while full)
//     o_fifo_wdata    FIFO write data
//     o_busy          arbiter not idle
//     o_grant_id      current or most recent grantee
//     o_trunc         one-cycle pulse after a packet is cut at MAXLEN
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int                NREQ    = 2,
  parameter int                DW      = 8,
  parameter int                IDW     = 3,
  parameter logic [DW-IDW-1:0] HDR_TAG = (DW-IDW)'(HDR_TAG_DEFAULT),
  parameter int                MAXLEN  = 64
) (
  input  logic                 wclk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*DW-1:0]   i_req_data,
  input  logic [NREQ-1:0]      i_req_last,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic                 i_fifo_full,
  output logic                 o_fifo_enqueue,
  output logic [DW-1:0]        o_fifo_wdata,
  output logic                 o_busy,
  output logic [IDW-1:0]       o_grant_id,
  output logic                 o_trunc
);

  localparam int CW = $clog2(MAXLEN + 1);

  arb_state_e       r_state;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_rr_ptr;
  logic [CW-1:0]    r_beat_cnt;
  logic             r_busy;
  logic             r_trunc;

  logic             w_pick_any;
  logic [IDW-1:0]   w_pick_idx;
  logic [NREQ-1:0]  w_grant_oh;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [DW-1:0]    w_sel_data;
  logic [DW-1:0]    w_hdr;
  logic             w_beat_acc;
  logic             w_pkt_end;
  logic [IDW-1:0]   w_next_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  // Grantee selection as a one-hot AND-OR mux, so no index wider than the
  // requester vector ever reaches the request buses.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_grant_oh[i] = (r_grant_id == IDW'(i));
      w_sel_data    = w_sel_data | ({DW{w_grant_oh[i]}} & i_req_data[i*DW +: DW]);
    end
    w_sel_valid = |(i_req_valid & w_grant_oh);
    w_sel_last  = |(i_req_last & w_grant_oh);
  end

  assign w_hdr      = DW'(build_hdr(32'(HDR_TAG), 32'(r_grant_id), IDW));
  assign w_beat_acc = (r_state == ST_DATA) && w_sel_valid && !i_fifo_full;
  // Packet ends on an explicit last beat or on the MAXLEN-th accepted beat.
  assign w_pkt_end  = w_sel_last || (r_beat_cnt == CW'(MAXLEN - 1));
  assign w_next_ptr = (r_grant_id == IDW'(NREQ - 1)) ? '0 : (r_grant_id + IDW'(1));

  // FIFO write port and requester handshake; combinational on state and
  // i_fifo_full so backpressure takes effect in the same cycle.
  always_comb begin
    o_fifo_enqueue = 1'b0;
    o_fifo_wdata   = '0;
    o_req_ready    = '0;
    case (r_state)
      ST_HEADER: begin
        o_fifo_enqueue = !i_fifo_full;
        o_fifo_wdata   = w_hdr;
      end
      ST_DATA: begin
        o_fifo_enqueue = w_sel_valid && !i_fifo_full;
        o_fifo_wdata   = w_sel_data;
        o_req_ready    = w_grant_oh & {NREQ{!i_fifo_full}};
      end
      default: begin
        o_fifo_enqueue = 1'b0;
        o_fifo_wdata   = '0;
        o_req_ready    = '0;
      end
    endcase
  end

  // Arbitration FSM with beat counter, round-robin pointer and status flags.
  always_ff @(posedge wclk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
      r_trunc    <= 1'b0;
    end else begin
      r_trunc <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant_id <= w_pick_idx;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (!i_fifo_full) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_beat_acc) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
            if (w_pkt_end) begin
              r_state  <= ST_IDLE;
              r_busy   <= 1'b0;
              r_rr_ptr <= w_next_ptr;
              // A cut packet: the requester's next beat opens a new packet.
              r_trunc  <= !w_sel_last;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_grant_id = r_grant_id;
  assign o_trunc    = r_trunc;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  localparam int NREQ   = 4;
  localparam int DW     = 8;
  localparam int IDW    = 3;
  localparam int MAXLEN = 4;

  logic              wclk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic              fifo_enqueue;
  logic [DW-1:0]     fifo_wdata;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              trunc;

  // requester beat queues {last, data}, expected FIFO words, enqueue cycles
  logic [8:0] rq [NREQ][$];
  logic [7:0] exp_q[$];
  int         enq_cyc_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int enq_cnt = 0;
  int full_seen = 0;
  int trunc_cnt = 0;
  int trunc_cyc = 0;
  int full_hold = 0;

  fifo_write_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .IDW     (IDW),
    .HDR_TAG (5'b10100),
    .MAXLEN  (MAXLEN)
  ) dut (
    .wclk           (wclk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .i_req_last     (req_last),
    .o_req_ready    (req_ready),
    .i_fifo_full    (fifo_full),
    .o_fifo_enqueue (fifo_enqueue),
    .o_fifo_wdata   (fifo_wdata),
    .o_busy         (busy),
    .o_grant_id     (grant_id),
    .o_trunc        (trunc)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge wclk); #3;
      if (exp_q.size() == 0 && all_empty() && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check(name, int'(done), 1);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    rst = 1'b0;
    full_hold = 0;
    repeat (2) @(negedge wclk);
    rst = 1'b1;
    #3;
  endtask

  // requester + full driver: drive at negedge, retire accepted beats at +1
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    forever begin
      @(negedge wclk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() != 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DW +: DW] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
      fifo_full = (full_hold > 0);
      if (full_hold > 0) full_hold--;
      #1;
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) void'(rq[i].pop_front());
    end
  end

  // monitor: scoreboard compare on every enqueue, full-path checks, trunc log
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge wclk); #2;
      if (fifo_enqueue) begin
        enq_cnt++;
        enq_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_enq: got %0h want none (cycle %0d)", fifo_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          check("wdata", int'(fifo_wdata), int'(e));
        end
      end
      if (fifo_full) begin
        full_seen++;
        check("enq_when_full", int'(fifo_enqueue), 0);
        check("ready_when_full", int'(req_ready), 0);
      end
      if (trunc) begin
        trunc_cnt++;
        trunc_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    int fs0;
    int tc0;
    bit found;

    // ---- reset values
    rst = 1'b0;
    repeat (3) @(negedge wclk);
    #3;
    check("rst_enqueue", int'(fifo_enqueue), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant", int'(grant_id), 0);
    check("rst_trunc", int'(trunc), 0);
    @(negedge wclk);
    rst = 1'b1;
    #3;

    // ---- single packet and arbitration latency
    enq_cyc_q.delete();
    send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0); send(0, 8'h33, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    found = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge wclk); #3;
      if (req_valid[0]) begin found = 1'b1; n = cyc; break; end
    end
    check("t1_valid_seen", int'(found), 1);
    check("t1_busy_idle", int'(busy), 0);
    repeat (4) begin @(negedge wclk); #3; end
    check("t1_busy_last", int'(busy), 1);
    @(negedge wclk); #3;
    check("t1_busy_fall", int'(busy), 0);
    wait_drain(50, "t1_drain");
    check("t1_enq_count", enq_cyc_q.size(), 4);
    check("t1_hdr_cyc", enq_cyc_q[0], n + 1);
    check("t1_b1_cyc", enq_cyc_q[1], n + 2);
    check("t1_b3_cyc", enq_cyc_q[3], n + 4);

    // ---- contention at reset exit, round-robin alternation
    do_reset();
    send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b1); send(0, 8'h05, 1'b0); send(0, 8'h06, 1'b1);
    send(1, 8'h03, 1'b0); send(1, 8'h04, 1'b1); send(1, 8'h07, 1'b0); send(1, 8'h08, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h07); exp_q.push_back(8'h08);
    wait_drain(100, "t2_drain");
    check("t2_last_grant", int'(grant_id), 1);

    // ---- backpressure: 5 full cycles after the second data beat
    enq_cyc_q.delete();
    send(0, 8'h51, 1'b0); send(0, 8'h52, 1'b0); send(0, 8'h53, 1'b0); send(0, 8'h54, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    exp_q.push_back(8'h53); exp_q.push_back(8'h54);
    base = enq_cnt;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge wclk); #3;
      if (enq_cnt - base >= 3) begin found = 1'b1; break; end
    end
    check("t3_reach_b2", int'(found), 1);
    fs0 = full_seen;
    full_hold = 5;
    wait_drain(60, "t3_drain");
    check("t3_full_cycles", full_seen - fs0, 5);
    check("t3_stall_gap", enq_cyc_q[3] - enq_cyc_q[2], 6);

    // ---- truncation at MAXLEN=4: 6 beats become 4 + 2
    enq_cyc_q.delete();
    tc0 = trunc_cnt;
    send(3, 8'h61, 1'b0); send(3, 8'h62, 1'b0); send(3, 8'h63, 1'b0);
    send(3, 8'h64, 1'b0); send(3, 8'h65, 1'b0); send(3, 8'h66, 1'b1);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    exp_q.push_back(8'h63); exp_q.push_back(8'h64);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h65); exp_q.push_back(8'h66);
    wait_drain(60, "t4_drain");
    check("t4_trunc_pulses", trunc_cnt - tc0, 1);
    check("t4_trunc_cyc", trunc_cyc, enq_cyc_q[4] + 1);

    // ---- reset mid-packet after beat 2 of 5
    send(2, 8'h71, 1'b0); send(2, 8'h72, 1'b0); send(2, 8'h73, 1'b0);
    send(2, 8'h74, 1'b0); send(2, 8'h75, 1'b1);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    base = enq_cnt;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge wclk); #3;
      if (enq_cnt - base >= 3) begin found = 1'b1; break; end
    end
    check("t5_reach_b2", int'(found), 1);
    rst = 1'b0;
    rq[2].delete();
    @(negedge wclk); #3;
    check("t5_rst_enqueue", int'(fifo_enqueue), 0);
    check("t5_rst_ready", int'(req_ready), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_grant", int'(grant_id), 0);
    check("t5_rst_trunc", int'(trunc), 0);
    @(negedge wclk);
    rst = 1'b1;
    #3;
    send(0, 8'h81, 1'b1);
    send(1, 8'h82, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h81);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h82);
    wait_drain(50, "t5_drain");

    // ---- wrap-around with four continuous requesters
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NREQ; i++) begin
        send(i, 8'(16 * (i + 1) + 2 * p), 1'b0);
        send(i, 8'(16 * (i + 1) + 2 * p + 1), 1'b1);
        exp_q.push_back(8'(8'hA0 + i));
        exp_q.push_back(8'(16 * (i + 1) + 2 * p));
        exp_q.push_back(8'(16 * (i + 1) + 2 * p + 1));
      end
    wait_drain(150, "t6_drain");
    check("t6_last_grant", int'(grant_id), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
